// File: rtl/network_frame_driver.sv
// Host-side driver for the Network core: gathers a serial sample stream into one parallel
// frame, fires the core, waits (bounded) for its end flag and returns the result over valid/ready.
module network_frame_driver #(
  parameter int unsigned N_INPUTS = 9,
  parameter int unsigned IN_W     = 33,
  parameter int unsigned OUT_W    = 34,
  parameter int unsigned TIMEOUT  = 1023
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     s_valid,
  input  logic [IN_W-1:0]          s_data,
  input  logic                     s_last,
  output logic                     s_ready,
  output logic                     net_start,
  output logic [N_INPUTS*IN_W-1:0] net_in,
  input  logic [OUT_W-1:0]         net_out,
  input  logic                     net_end,
  output logic                     r_valid,
  output logic [OUT_W-1:0]         r_data,
  output logic                     r_timeout,
  input  logic                     r_ready,
  output logic                     err_frame
);

  localparam int unsigned IdxW = (N_INPUTS > 1) ? $clog2(N_INPUTS) : 1;
  localparam int unsigned TmrW = $clog2(TIMEOUT + 1);
  localparam logic [IdxW-1:0] LastIdx  = IdxW'(N_INPUTS - 1);
  localparam logic [TmrW-1:0] LastTick = TmrW'(TIMEOUT - 1);

  typedef enum logic [1:0] {StCollect, StFire, StWait, StHold} state_e;

  state_e            state_q, state_d;
  logic [IdxW-1:0]   idx_q, idx_d;
  logic [TmrW-1:0]   timer_q, timer_d;
  logic [OUT_W-1:0]  r_data_q, r_data_d;
  logic              r_timeout_q, r_timeout_d;
  logic              err_q, err_d;
  logic              beat;
  logic [IN_W-1:0]   slot_q [N_INPUTS];

  assign beat = s_valid && (state_q == StCollect);

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    timer_d     = timer_q;
    r_data_d    = r_data_q;
    r_timeout_d = r_timeout_q;
    err_d       = 1'b0;
    unique case (state_q)
      StCollect: begin
        if (beat) begin
          if (idx_q == LastIdx) begin
            idx_d = '0;
            if (s_last) state_d = StFire;
            else        err_d   = 1'b1;
          end else if (s_last) begin
            idx_d = '0;
            err_d = 1'b1;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      StFire: begin
        timer_d = '0;
        state_d = StWait;
      end
      StWait: begin
        // A done flag on the final timer cycle still counts as a real result.
        if (net_end) begin
          r_data_d    = net_out;
          r_timeout_d = 1'b0;
          state_d     = StHold;
        end else if (timer_q == LastTick) begin
          r_data_d    = '0;
          r_timeout_d = 1'b1;
          state_d     = StHold;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      StHold: begin
        if (r_ready) state_d = StCollect;
      end
      default: state_d = StCollect;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StCollect;
      idx_q       <= '0;
      timer_q     <= '0;
      r_data_q    <= '0;
      r_timeout_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      timer_q     <= timer_d;
      r_data_q    <= r_data_d;
      r_timeout_q <= r_timeout_d;
      err_q       <= err_d;
    end
  end

  // Slots are only written while collecting, so net_in stays frozen from FIRE through HOLD.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < N_INPUTS; k++) slot_q[k] <= '0;
    end else if (beat) begin
      slot_q[idx_q] <= s_data;
    end
  end

  for (genvar g = 0; g < N_INPUTS; g++) begin : g_net_in
    assign net_in[g*IN_W +: IN_W] = slot_q[g];
  end

  assign s_ready   = (state_q == StCollect);
  assign net_start = (state_q == StFire);
  assign r_valid   = (state_q == StHold);
  assign r_data    = r_data_q;
  assign r_timeout = r_timeout_q;
  assign err_frame = err_q;

endmodule

// File: tb/tb_network_frame_driver.sv
// Randomized bench for network_frame_driver with a frame-level reference model.
module tb_network_frame_driver;

  localparam int unsigned N  = 9;
  localparam int unsigned IW = 33;
  localparam int unsigned OW = 34;
  localparam int unsigned TO = 8;

  logic            clk = 1'b0;
  logic            rst;
  logic            s_valid;
  logic [IW-1:0]   s_data;
  logic            s_last;
  logic            s_ready;
  logic            net_start;
  logic [N*IW-1:0] net_in;
  logic [OW-1:0]   net_out;
  logic            net_end;
  logic            r_valid;
  logic [OW-1:0]   r_data;
  logic            r_timeout;
  logic            r_ready;
  logic            err_frame;

  network_frame_driver #(
    .N_INPUTS(N),
    .IN_W    (IW),
    .OUT_W   (OW),
    .TIMEOUT (TO)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .s_valid  (s_valid),
    .s_data   (s_data),
    .s_last   (s_last),
    .s_ready  (s_ready),
    .net_start(net_start),
    .net_in   (net_in),
    .net_out  (net_out),
    .net_end  (net_end),
    .r_valid  (r_valid),
    .r_data   (r_data),
    .r_timeout(r_timeout),
    .r_ready  (r_ready),
    .err_frame(err_frame)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Samples accepted since the last frame boundary (the model's view of the open frame).
  logic [IW-1:0] pend[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [IW-1:0] rnd_sample();
    return IW'({$urandom(), $urandom()});
  endfunction

  function automatic logic [OW-1:0] rnd_result();
    return OW'({$urandom(), $urandom()});
  endfunction

  task automatic check_reset_outputs();
    check("rst_s_ready", 64'(s_ready), 64'd1);
    check("rst_net_start", 64'(net_start), 64'd0);
    check("rst_r_valid", 64'(r_valid), 64'd0);
    check("rst_r_data", 64'(r_data), 64'd0);
    check("rst_r_timeout", 64'(r_timeout), 64'd0);
    check("rst_err_frame", 64'(err_frame), 64'd0);
    check("rst_net_in", 64'(|net_in), 64'd0);
  endtask

  // outcome: 0 = frame continues, 1 = malformed frame dropped, 2 = frame fires
  task automatic beat(input logic [IW-1:0] d, input logic last, output int outcome);
    s_valid = 1'b1;
    s_data  = d;
    s_last  = last;
    check("s_ready_collect", 64'(s_ready), 64'd1);
    pend.push_back(d);
    if (last && pend.size() == N)      outcome = 2;
    else if (last || pend.size() == N) outcome = 1;
    else                               outcome = 0;
    tick();
    s_valid = 1'b0;
    s_last  = 1'b0;
    check("err_frame", 64'(err_frame), 64'(outcome == 1));
    check("net_start_after_beat", 64'(net_start), 64'(outcome == 2));
    check("r_valid_collect", 64'(r_valid), 64'd0);
    if (outcome == 1) pend.delete();
  endtask

  // Sends n samples, s_last on sample last_pos (0 = never); returns 1 if the frame fired.
  task automatic send_frame(input int n, input int last_pos, input bit seq, output bit fired);
    int oc;
    fired = 1'b0;
    for (int i = 1; i <= n; i++) begin
      beat(seq ? IW'(i) : rnd_sample(), i == last_pos, oc);
      if (oc == 2) begin
        fired = 1'b1;
        return;
      end
      for (int g = $urandom_range(0, 2); g > 0; g--) begin
        tick();
        check("err_frame_one_cycle", 64'(err_frame), 64'd0);
        check("s_ready_idle", 64'(s_ready), 64'd1);
      end
    end
    tick();
    check("err_frame_one_cycle", 64'(err_frame), 64'd0);
    check("s_ready_after_frame", 64'(s_ready), 64'd1);
    check("net_start_none", 64'(net_start), 64'd0);
  endtask

  // Entered in the FIRE cycle. Core answers d cycles after start (d=0 lands in FIRE, ignored).
  task automatic serve(input int d, input logic [OW-1:0] val, input int hold_n);
    logic [IW-1:0] fr[N];
    bit            to;
    int            exp_k;
    logic [OW-1:0] exp_data;
    for (int k = 0; k < N; k++) fr[k] = pend[k];
    pend.delete();
    to       = !(d >= 1 && d <= int'(TO));
    exp_k    = to ? int'(TO) + 1 : d + 1;
    exp_data = to ? '0 : val;
    for (int k = 0; k < exp_k; k++) begin
      net_end = (k == d);
      net_out = (k == d) ? val : rnd_result();
      check("net_start_pulse", 64'(net_start), 64'(k == 0));
      check("s_ready_busy", 64'(s_ready), 64'd0);
      check("r_valid_early", 64'(r_valid), 64'd0);
      if (k == 0)
        for (int s = 0; s < N; s++) check("net_in_slot", 64'(net_in[s*IW +: IW]), 64'(fr[s]));
      tick();
    end
    net_end = 1'b0;
    net_out = rnd_result();
    for (int j = 0; j <= hold_n; j++) begin
      check("r_valid_hold", 64'(r_valid), 64'd1);
      check("r_data", 64'(r_data), 64'(exp_data));
      check("r_timeout", 64'(r_timeout), 64'(to));
      check("s_ready_hold", 64'(s_ready), 64'd0);
      check("err_frame_hold", 64'(err_frame), 64'd0);
      if (j == hold_n) break;
      s_valid = 1'($urandom());
      s_data  = rnd_sample();
      tick();
    end
    for (int s = 0; s < N; s++) check("net_in_stable", 64'(net_in[s*IW +: IW]), 64'(fr[s]));
    s_valid = 1'b0;
    r_ready = 1'b1;
    tick();
    r_ready = 1'b0;
    check("r_valid_after_hs", 64'(r_valid), 64'd0);
    check("s_ready_after_hs", 64'(s_ready), 64'd1);
  endtask

  initial begin
    bit fired;
    int n;
    int lp;
    rst = 1'b1; s_valid = 1'b0; s_data = '0; s_last = 1'b0;
    net_out = '0; net_end = 1'b0; r_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    check_reset_outputs();

    // Clean frame 1..9, core answers 5 cycles after start.
    send_frame(N, N, 1'b1, fired);
    check("t1_fired", 64'(fired), 64'd1);
    if (fired) serve(5, OW'(-12345), 0);

    // Early s_last, then a clean frame.
    send_frame(4, 4, 1'b0, fired);
    check("t2_no_fire", 64'(fired), 64'd0);
    send_frame(N, N, 1'b0, fired);
    check("t2_clean_fired", 64'(fired), 64'd1);
    if (fired) serve(1, rnd_result(), 0);

    // Missing s_last.
    send_frame(N, 0, 1'b0, fired);
    check("t3_no_fire", 64'(fired), 64'd0);

    // Timeout, and net_end on the last timer cycle.
    send_frame(N, N, 1'b0, fired);
    if (fired) serve(-1, rnd_result(), 0);
    send_frame(N, N, 1'b0, fired);
    if (fired) serve(int'(TO), rnd_result(), 0);

    // Long backpressure in HOLD.
    send_frame(N, N, 1'b0, fired);
    if (fired) serve(3, rnd_result(), 20);

    // Reset during WAIT; a late net_end must be ignored.
    send_frame(N, N, 1'b0, fired);
    check("t6_fired", 64'(fired), 64'd1);
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    pend.delete();
    check_reset_outputs();
    net_end = 1'b1;
    net_out = rnd_result();
    tick();
    net_end = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check("t6_no_r_valid", 64'(r_valid), 64'd0);
      check("t6_no_start", 64'(net_start), 64'd0);
      check("t6_s_ready", 64'(s_ready), 64'd1);
      tick();
    end

    // Randomized traffic.
    for (int it = 0; it < 60; it++) begin
      case ($urandom_range(0, 3))
        0:       begin n = $urandom_range(1, N - 1); lp = n; end
        1:       begin n = N; lp = 0; end
        default: begin n = N; lp = N; end
      endcase
      send_frame(n, lp, 1'b0, fired);
      check("rand_fire", 64'(fired), 64'(lp == int'(N)));
      if (fired) serve($urandom_range(0, TO + 3), rnd_result(), $urandom_range(0, 3));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
